instr_imm_decode_stage: RTL and testbench
=========================================

// Module: instr_imm_decode_stage
// PURPOSE
//   Registered decode stage sitting directly upstream of the 10->18-bit sign extender.
//   Accepts 18-bit instruction words over a valid/ready handshake and splits each word
//   into opcode, destination register and raw 10-bit immediate. The immediate feeds the
//   sign extender; the other fields feed the execute stage.
//   Contains a 2-entry skid buffer so that in_ready is a registered signal, plus a
//   saturating counter of illegal opcodes.
// PARAMETERS
//   INSTR_W     18        instruction word width
//   IMM_W       10        immediate field width (bits [IMM_W-1:0])
//   OPC_W       4         opcode width (bits [17:14])
//   RD_W        4         destination register field (bits [13:10])
//   LEGAL_MASK  16'h0FFF  bit n set = opcode n is legal
//   CNT_W       16        illegal-opcode counter width
// PORTS
//   clk           in   1        single clock, rising edge
//   rst           in   1        synchronous, active-high reset
//   in_valid      in   1        upstream word valid
//   in_ready      out  1        stage can accept; registered
//   in_instr      in   INSTR_W  instruction word
//   out_valid     out  1        decoded fields valid
//   out_ready     in   1        downstream accepts
//   out_opcode    out  OPC_W    instr[17:14]
//   out_rd        out  RD_W     instr[13:10]
//   out_imm       out  IMM_W    instr[9:0], raw; goes to the sign extender input
//   out_illegal   out  1        opcode not set in LEGAL_MASK
//   illegal_cnt   out  CNT_W    count of illegal words accepted; saturating
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     out_valid=0, in_ready=0 during reset, in_ready=1 on the first cycle after reset.
//     out_opcode/out_rd/out_imm/out_illegal=0, illegal_cnt=0. Both buffer entries empty.
//   Handshakes:
//     - Input transfer  = in_valid & in_ready. Output transfer = out_valid & out_ready.
//     - in_ready depends only on registered state; no comb path from out_ready.
//     - Output fields are stable while out_valid=1 and out_ready=0.
//   Latency: a word accepted at edge N is presented at out_* after edge N (1 cycle),
//     when the stage is EMPTY.
//   FSM (main register M, skid register S):
//     EMPTY: in_ready=1, out_valid=0. Input transfer -> M, go to ONE.
//     ONE:   in_ready=1, out_valid=1.
//            - in only:      word -> S, go to TWO.
//            - out only:     go to EMPTY.
//            - both:         word -> M, stay ONE.
//            - neither:      hold.
//     TWO:   in_ready=0, out_valid=1.
//            - out transfer: S -> M, go to ONE.
//            - otherwise:    hold.
//   Ordering: strict FIFO; words never drop or duplicate.
//   Decode: combinational from the stored word. out_illegal = ~LEGAL_MASK[opcode].
//   illegal_cnt:
//     - +1 on each input transfer whose opcode is illegal.
//     - Saturates at 2^CNT_W-1, no wrap.
//     - Counts at input acceptance, not at output.
//   Mid-operation reset: all contents discarded, returns to EMPTY, counter cleared.
//     No output transfer occurs in the reset cycle.
// STRUCTURE
//   Package instr_pkg:
//     - Field positions (OPC_MSB=17, RD_MSB=13, IMM_MSB=9).
//     - Opcode localparams.
//     - Default LEGAL_MASK.
//     - instr_fields_t struct {opcode, rd, imm}.
//   Sub-module instr_field_decoder: purely combinational; instr -> fields + illegal flag.
//     Instantiated once on the M output.
//   Top level holds the FSM, M/S registers and the counter.
//     Its out_imm drives signExtender10To18bits.inp in the datapath.
// TESTING
//   1. Reset, then in_instr=18'b0001_0011_1000000000, out_ready=1
//      -> next cycle: out_opcode=1, out_rd=3, out_imm=10'h200, out_illegal=0;
//         sign-extended value 18'h3FE00.
//   2. out_ready=0, push 3 words A, B, C
//      -> A and B accepted, in_ready=0 on the cycle after B, C held upstream;
//         then out_ready=1 -> outputs A, B, C in order, no gaps after the first.
//   3. Steady streaming with in_valid=out_ready=1 over 8 words
//      -> one word out per cycle, state stays ONE, in_ready stays 1.
//   4. Push opcode 4'hF (illegal under the default mask) twice
//      -> out_illegal=1 for both, illegal_cnt=2.
//      Force the counter to 16'hFFFF, push one more illegal word -> stays 16'hFFFF.
//   5. Assert rst for 1 cycle while in state TWO
//      -> out_valid=0 and illegal_cnt=0 on the next cycle,
//         in_ready=1 one cycle after rst deasserts, no stale word appears.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction immediate decode stage: field layout,
// opcode names, default legal-opcode mask, decoded field bundle and FSM states.
package instr_pkg;

  localparam int INSTR_W = 18;
  localparam int IMM_W   = 10;
  localparam int OPC_W   = 4;
  localparam int RD_W    = 4;
  localparam int CNT_W   = 16;

  // MSB position of each field inside the instruction word
  localparam int OPC_MSB = 17;
  localparam int RD_MSB  = 13;
  localparam int IMM_MSB = 9;

  // Opcode map; 4'hC..4'hF are reserved and therefore illegal by default
  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADDI = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SUBI = 4'h2;
  localparam logic [OPC_W-1:0] OPC_ANDI = 4'h3;
  localparam logic [OPC_W-1:0] OPC_ORI  = 4'h4;
  localparam logic [OPC_W-1:0] OPC_XORI = 4'h5;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'h6;
  localparam logic [OPC_W-1:0] OPC_LD   = 4'h7;
  localparam logic [OPC_W-1:0] OPC_ST   = 4'h8;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 4'h9;
  localparam logic [OPC_W-1:0] OPC_BNE  = 4'hA;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'hB;

  localparam logic [(1<<OPC_W)-1:0] DEFAULT_LEGAL_MASK = 16'h0FFF;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [RD_W-1:0]  rd;
    logic [IMM_W-1:0] imm;
  } instr_fields_t;

  // Occupancy of the main/skid register pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // True when the opcode has its bit set in the legal mask
  function automatic logic opcode_legal(input logic [(1<<OPC_W)-1:0] mask,
                                        input logic [OPC_W-1:0] opcode);
    return mask[opcode];
  endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Purely combinational split of an instruction word into opcode, rd and raw
// immediate, plus the illegal-opcode flag.
module instr_field_decoder
  import instr_pkg::*;
#(
  parameter logic [(1<<OPC_W)-1:0] LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
  input  logic [INSTR_W-1:0] instr,
  output instr_fields_t      fields,
  output logic               illegal
);

  assign fields.opcode = instr[OPC_MSB -: OPC_W];
  assign fields.rd     = instr[RD_MSB  -: RD_W];
  assign fields.imm    = instr[IMM_MSB -: IMM_W];
  assign illegal       = ~opcode_legal(LEGAL_MASK, fields.opcode);

endmodule

// File: rtl/instr_imm_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main M, skid S) so that
// in_ready comes straight from a flop. Fields are decoded from M; the raw
// immediate feeds the downstream 10->18-bit sign extender. Also keeps a
// saturating count of illegal opcodes seen at input acceptance.
module instr_imm_decode_stage
  import instr_pkg::*;
#(
  parameter logic [(1<<OPC_W)-1:0] LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [RD_W-1:0]    out_rd,
  output logic [IMM_W-1:0]   out_imm,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  state_t             state_q, state_next;
  logic [INSTR_W-1:0] m_q, s_q;
  logic               in_ready_q;
  logic [CNT_W-1:0]   cnt_q;

  logic          in_xfer, out_xfer, in_illegal;
  logic          m_load_in, m_load_s, s_load;
  instr_fields_t m_fields;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  assign in_illegal = ~opcode_legal(LEGAL_MASK, in_instr[OPC_MSB -: OPC_W]);

  // Next-state and register-load selection for the skid buffer
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_next = state_q;
    m_load_in  = 1'b0;
    m_load_s   = 1'b0;
    s_load     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          m_load_in  = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          m_load_in = 1'b1;
        end else if (in_xfer) begin
          s_load     = 1'b1;
          state_next = ST_TWO;
        end else if (out_xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          m_load_s   = 1'b1;
          state_next = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // State, data registers, registered ready and illegal-opcode counter
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge
    // values of its neighbours regardless of statement order.
    if (rst) begin
      // Both buffer entries are cleared (not just invalidated) so the decoded
      // fields read zero straight out of reset.
      state_q    <= ST_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_next;
      if (m_load_in)     m_q <= in_instr;
      else if (m_load_s) m_q <= s_q;
      if (s_load)        s_q <= in_instr;
      // Ready for the next cycle depends only on where the FSM is going
      in_ready_q <= (state_next != ST_TWO);
      if (in_xfer && in_illegal && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  instr_field_decoder #(
    .LEGAL_MASK (LEGAL_MASK)
  ) u_decoder (
    .instr   (m_q),
    .fields  (m_fields),
    .illegal (out_illegal)
  );

  assign out_opcode  = m_fields.opcode;
  assign out_rd      = m_fields.rd;
  assign out_imm     = m_fields.imm;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_imm_decode_stage.sv
// Self-checking bench for instr_imm_decode_stage: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_instr_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [9:0]  out_imm;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: words held by the stage in arrival order, the expected
  // registered ready, and the saturating illegal count.
  logic [17:0] mq[$];
  logic        m_rdy = 1'b0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  instr_imm_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Opcodes 12..15 are the reserved (illegal) ones under the default mask
  function automatic logic model_illegal(input logic [17:0] w);
    return (w[17:14] >= 4'd12);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare every DUT output shortly after the edge.
  task automatic step(input logic r, input logic iv, input logic [17:0] w, input logic ordy);
    logic in_x, out_x;
    rst       = r;
    in_valid  = iv;
    in_instr  = w;
    out_ready = ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = 0;
    end else begin
      in_x  = iv && m_rdy;
      out_x = ordy && (mq.size() > 0);
      if (out_x) void'(mq.pop_front());
      if (in_x) begin
        mq.push_back(w);
        if (model_illegal(w) && m_cnt < 65535) m_cnt++;
      end
      m_rdy = (mq.size() < 2);
    end
    #1;
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (mq.size() > 0) begin
      check("out_opcode", 32'(out_opcode), 32'(mq[0][17:14]));
      check("out_rd", 32'(out_rd), 32'(mq[0][13:10]));
      check("out_imm", 32'(out_imm), 32'(mq[0][9:0]));
      check("out_illegal", 32'(out_illegal), 32'(model_illegal(mq[0])));
    end else if (r) begin
      check("rst_fields", {13'd0, out_opcode, out_rd, out_imm, out_illegal}, 32'd0);
    end
  endtask

  initial begin
    logic [17:0] w;
    logic [17:0] sext;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 18'h0, 1'b0);
    step(1'b1, 1'b1, 18'h3FFFF, 1'b1);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b0, 18'h0, 1'b1);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // 1: single word, one-cycle latency, sign-extension view of out_imm
    step(1'b0, 1'b1, 18'b0001_0011_1000000000, 1'b1);
    check("t1_opcode", 32'(out_opcode), 32'd1);
    check("t1_rd", 32'(out_rd), 32'd3);
    check("t1_imm", 32'(out_imm), 32'h200);
    check("t1_illegal", 32'(out_illegal), 32'd0);
    sext = {{8{out_imm[9]}}, out_imm};
    check("t1_sext", 32'(sext), 32'h3FE00);
    step(1'b0, 1'b0, 18'h0, 1'b1);

    // 2: backpressure with A, B, C; then drain in order
    step(1'b0, 1'b1, {4'h2, 4'h1, 10'h0AA}, 1'b0);
    step(1'b0, 1'b1, {4'h3, 4'h2, 10'h0BB}, 1'b0);
    check("t2_full_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, {4'h4, 4'h3, 10'h0CC}, 1'b0);
    check("t2_hold_A", 32'(out_imm), 32'h0AA);
    step(1'b0, 1'b1, {4'h4, 4'h3, 10'h0CC}, 1'b1);
    check("t2_B", 32'(out_imm), 32'h0BB);
    step(1'b0, 1'b1, {4'h4, 4'h3, 10'h0CC}, 1'b1);
    check("t2_C", 32'(out_imm), 32'h0CC);
    step(1'b0, 1'b0, 18'h0, 1'b1);
    check("t2_drained", 32'(out_valid), 32'd0);

    // 3: steady streaming, one word per cycle
    for (int i = 0; i < 8; i++) begin
      w = {4'(i), 4'(i + 1), 10'($urandom)};
      step(1'b0, 1'b1, w, 1'b1);
      check("t3_ready", 32'(in_ready), 32'd1);
      check("t3_word", 32'(out_imm), 32'(w[9:0]));
    end
    step(1'b0, 1'b0, 18'h0, 1'b1);

    // 4: illegal opcodes counted, then saturation
    step(1'b1, 1'b0, 18'h0, 1'b0);
    step(1'b0, 1'b0, 18'h0, 1'b1);
    step(1'b0, 1'b1, {4'hF, 4'h2, 10'h155}, 1'b1);
    check("t4_illegal_a", 32'(out_illegal), 32'd1);
    step(1'b0, 1'b1, {4'hF, 4'h5, 10'h2AA}, 1'b1);
    check("t4_illegal_b", 32'(out_illegal), 32'd1);
    check("t4_cnt2", 32'(illegal_cnt), 32'd2);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 65535;
    step(1'b0, 1'b1, {4'hD, 4'h1, 10'h001}, 1'b1);
    check("t4_saturate", 32'(illegal_cnt), 32'hFFFF);
    step(1'b0, 1'b0, 18'h0, 1'b1);

    // 5: reset while both entries are occupied
    step(1'b0, 1'b1, {4'hE, 4'h1, 10'h111}, 1'b0);
    step(1'b0, 1'b1, {4'h1, 4'h2, 10'h222}, 1'b0);
    check("t5_in_two", 32'(in_ready), 32'd0);
    step(1'b1, 1'b1, {4'h2, 4'h3, 10'h333}, 1'b1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_cnt", 32'(illegal_cnt), 32'd0);
    step(1'b0, 1'b0, 18'h0, 1'b1);
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_no_stale", 32'(out_valid), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
           18'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
